instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage sitting directly upstream of the instruction memory and feeding the decode stage. It owns the program counter and drives the byte address to the instruction memory. The memory returns the word combinationally in the same cycle. The stage registers that word, with its PC, into an IF/ID output register using a valid/ready handshake. It also accepts branch/jump redirects from execute, which flush the output register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0013, instruction value held on the output when it is invalid (addi x0,x0,0).

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
fetch_enable  input  1  when 1, the stage may fetch new instructions.
inst_addr  output  32  byte address to instruction memory; always equals the PC register.
inst_rdata  input  32  instruction word from memory; combinational in inst_addr, same cycle.
redirect_valid  input  1  taken branch/jump from execute.
redirect_target  input  32  byte target address for the redirect.
out_valid  output  1  IF/ID register holds a valid instruction.
out_ready  input  1  decode accepts the output this cycle.
out_instruction  output  32  registered instruction.
out_pc  output  32  byte address of out_instruction.
misaligned_err  output  1  sticky flag; set when a redirect target has bits [1:0] != 0.
fetch_count  output  32  number of instructions accepted by decode (out_valid & out_ready).

Behaviour:
- Reset values (asynchronous, on reset_n low): pc=RESET_PC, out_valid=0, out_instruction=NOP_INSTR, out_pc=0, misaligned_err=0, fetch_count=0. Deassertion takes effect at the next rising edge.
- inst_addr = pc, combinational from the PC register. PC always holds bits [1:0]=00.
- Define accept = out_valid & out_ready. Define slot_free = !out_valid | out_ready.
- Each edge, priority order:
  1. redirect_valid=1:
     - pc <= {redirect_target[31:2],2'b00}
     - out_valid <= 0; out_instruction <= NOP_INSTR
     - misaligned_err <= misaligned_err | (redirect_target[1:0]!=0)
     - A held instruction is discarded even if out_ready=0.
     - If accept=1 in this same cycle, that instruction counts as delivered and fetch_count increments.
  2. slot_free & fetch_enable:
     - out_instruction <= inst_rdata; out_pc <= pc; out_valid <= 1
     - pc <= pc + 4
  3. slot_free & !fetch_enable:
     - out_valid <= 0; out_instruction <= NOP_INSTR; pc holds.
  4. Otherwise (out_valid & !out_ready, the backpressure case): pc, out_valid, out_instruction and out_pc all hold unchanged.
- Latency: one cycle from PC to output. At full throughput, one instruction per cycle.
- The first valid output appears on the first edge after reset release with fetch_enable=1. The first instruction after a redirect is valid one edge after the redirect edge.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. No error is raised.
- fetch_count increments on every accept, including cycles with a redirect. It wraps modulo 2^32.
- misaligned_err clears only on reset.
- out_* outputs are stable while out_valid=1 and out_ready=0, unless a redirect occurs.
- Reset asserted mid-stall or mid-redirect forces all reset values immediately.

Decomposition:
- Shared package: NOP_INSTR constant, RESET_PC default, and an XLEN=32 constant for widths.
- One natural sub-module, if_id_reg: the valid/ready output register, with flush and load/hold controls.
- PC logic, redirect priority and the counter stay in instruction_fetch.

Test Plan:
- Reset then fetch_enable=1, out_ready=1, memory preloaded at words 0..3 -> out_pc sequence 0,4,8,12 on consecutive cycles. The first instruction is 32'h003100B3 (add x1,x2,x3). fetch_count reaches 4.
- Backpressure: out_ready=0 for 3 cycles while out_pc=8 -> out_pc=8 and out_instruction held, inst_addr=12 held. Release -> next out_pc=12 with no skipped or duplicated instruction.
- Redirect while stalled: out_valid=1, out_ready=0, redirect_valid=1, target=0x18 -> next cycle out_valid=0, out_instruction=NOP. The following cycle out_pc=0x18. fetch_count unchanged.
- Misaligned redirect: target=0x0000_0022 -> pc=0x20, misaligned_err=1. The flag stays set through later redirects until reset_n pulses low.
- Wrap: RESET_PC=32'hFFFF_FFF8, continuous fetch -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Asynchronous reset mid-stream, asserted between clock edges -> out_valid=0, out_instruction=NOP_INSTR, inst_addr=RESET_PC immediately without a clock edge. fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants, IF/ID register control encoding and address helpers
// for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP           = 32'h0000_0004;

  typedef enum logic [1:0] {
    IF_FLUSH = 2'd0,
    IF_LOAD  = 2'd1,
    IF_CLEAR = 2'd2,
    IF_HOLD  = 2'd3
  } if_op_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: flush, load, clear-to-bubble or hold, selected
// by a single registered-op code from the fetch control logic.
module if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  if_op_e          op,
  input  logic [XLEN-1:0] load_instruction,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc
);

  logic            valid_r;
  logic [XLEN-1:0] instruction_r;
  logic [XLEN-1:0] pc_r;

  // Output register update; the PC field is left untouched by flush/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r       <= 1'b0;
      instruction_r <= NOP_INSTR;
      pc_r          <= {XLEN{1'b0}};
    end else begin
      case (op)
        IF_FLUSH, IF_CLEAR: begin
          valid_r       <= 1'b0;
          instruction_r <= NOP_INSTR;
        end
        IF_LOAD: begin
          valid_r       <= 1'b1;
          instruction_r <= load_instruction;
          pc_r          <= load_pc;
        end
        IF_HOLD: begin
          valid_r       <= valid_r;
          instruction_r <= instruction_r;
          pc_r          <= pc_r;
        end
        default: begin
          valid_r       <= 1'b0;
          instruction_r <= NOP_INSTR;
        end
      endcase
    end
  end

  assign valid       = valid_r;
  assign instruction = instruction_r;
  assign pc          = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory, and registers the
// returned word into the IF/ID register; execute redirects flush that register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_enable,
  output logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] inst_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc,
  output logic            misaligned_err,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic            misaligned_err_r;
  logic [XLEN-1:0] fetch_count_r;
  logic            out_valid_s;
  logic            accept_s;
  logic            slot_free_s;
  if_op_e          op_s;

  assign accept_s    = out_valid_s & out_ready;
  assign slot_free_s = ~out_valid_s | out_ready;

  // Redirect beats a new fetch, which beats inserting a bubble; else stall.
  always_comb begin
    op_s      = IF_HOLD;
    pc_next_s = pc_r;
    if (redirect_valid) begin
      op_s      = IF_FLUSH;
      pc_next_s = word_align(redirect_target);
    end else if (slot_free_s && fetch_enable) begin
      op_s      = IF_LOAD;
      pc_next_s = pc_r + PC_STEP;
    end else if (slot_free_s) begin
      op_s      = IF_CLEAR;
      pc_next_s = pc_r;
    end else begin
      op_s      = IF_HOLD;
      pc_next_s = pc_r;
    end
  end

  // PC, sticky misalignment flag and delivered-instruction counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r             <= word_align(RESET_PC);
      misaligned_err_r <= 1'b0;
      fetch_count_r    <= {XLEN{1'b0}};
    end else begin
      pc_r <= pc_next_s;
      if (redirect_valid) begin
        misaligned_err_r <= misaligned_err_r | is_misaligned(redirect_target);
      end else begin
        misaligned_err_r <= misaligned_err_r;
      end
      // Accepts in a redirect cycle still count as delivered.
      if (accept_s) begin
        fetch_count_r <= fetch_count_r + 32'h0000_0001;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk              (clk),
    .reset_n          (reset_n),
    .op               (op_s),
    .load_instruction (inst_rdata),
    .load_pc          (pc_r),
    .valid            (out_valid_s),
    .instruction      (out_instruction),
    .pc               (out_pc)
  );

  assign inst_addr      = pc_r;
  assign out_valid      = out_valid_s;
  assign misaligned_err = misaligned_err_r;
  assign fetch_count    = fetch_count_r;

endmodule
